// File: rtl/lcd_pkg.sv
// lcd_pkg: shared geometry, types and palette helpers for the LCD scanout
// path. Imported by lcd_scan_timing and lcd_scanout.
package lcd_pkg;

  localparam int LCD_W      = 160;
  localparam int LCD_H      = 144;
  localparam int LCD_PIXELS = LCD_W * LCD_H;  // 23040
  localparam int ADDR_W     = 15;

  typedef logic [1:0]        shade_t;
  typedef logic [ADDR_W-1:0] pix_addr_t;
  typedef logic [3:0][7:0]   palette_t;       // index = shade

  localparam logic [7:0] SHADE0_DEF = 8'hFF;  // white
  localparam logic [7:0] SHADE1_DEF = 8'hAA;
  localparam logic [7:0] SHADE2_DEF = 8'h55;
  localparam logic [7:0] SHADE3_DEF = 8'h00;  // black

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic hblank;
    logic vblank;
  } sync_t;

  // Idle raster state: both blanks asserted, no sync.
  localparam sync_t SYNC_IDLE = '{hsync: 1'b0, vsync: 1'b0, hblank: 1'b1, vblank: 1'b1};

  function automatic logic [7:0] shade_grey(input shade_t s, input palette_t pal);
    return pal[s];
  endfunction

endpackage

// File: rtl/lcd_scan_timing.sv
// lcd_scan_timing: output raster generator for the LCD scanout.
//   clk, reset  : system clock, synchronous active-high reset
//   ce_pix      : pixel enable; counters advance only when high
//   raddr       : frame-buffer address of the current pixel (running count)
//   sync_a      : hsync/vsync/hblank/vblank decoded from the current counters
//   active      : current pixel lies inside the 160x144 window
module lcd_scan_timing
  import lcd_pkg::*;
#(
  parameter int H_FP   = 16,
  parameter int H_SYNC = 16,
  parameter int H_BP   = 32,
  parameter int V_FP   = 3,
  parameter int V_SYNC = 3,
  parameter int V_BP   = 12
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      ce_pix,
  output pix_addr_t raddr,
  output sync_t     sync_a,
  output logic      active
);

  localparam int H_TOTAL = LCD_W + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = LCD_H + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT  = HW'(LCD_W);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_ON  = HW'(LCD_W + H_FP);
  localparam logic [HW-1:0] HS_OFF = HW'(LCD_W + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT  = VW'(LCD_H);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_ON  = VW'(LCD_H + V_FP);
  localparam logic [VW-1:0] VS_OFF = VW'(LCD_H + V_FP + V_SYNC);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          h_end;
  logic          v_end;

  assign h_end  = (hcnt == H_LAST);
  assign v_end  = (vcnt == V_LAST);
  assign active = (hcnt < H_ACT) && (vcnt < V_ACT);

  // raddr counts active pixels since the top-left corner, which equals
  // vcnt*160+hcnt inside the window without needing a multiplier.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt  <= '0;
      vcnt  <= '0;
      raddr <= '0;
    end else if (ce_pix) begin
      if (h_end) begin
        hcnt <= '0;
        vcnt <= v_end ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
      if (h_end && v_end) raddr <= '0;
      else if (active)    raddr <= raddr + 1'b1;
    end
  end

  always_comb begin
    sync_a        = SYNC_IDLE;
    sync_a.hsync  = (hcnt >= HS_ON) && (hcnt < HS_OFF);
    sync_a.vsync  = (vcnt >= VS_ON) && (vcnt < VS_OFF);
    sync_a.hblank = (hcnt >= H_ACT);
    sync_a.vblank = (vcnt >= V_ACT);
  end

endmodule

// File: rtl/lcd_scanout.sv
// lcd_scanout: captures the LCD pixel stream into a 160x144x2 frame buffer
// and rescans it with independent raster timing.
//   clk, reset        : system clock, synchronous active-high reset
//   lcd_on            : LCD enable; low restarts capture at pixel 0
//   lcd_clkena        : one pulse per valid input pixel
//   lcd_data          : input pixel shade
//   ce_pix            : output pixel enable
//   frame_done        : 1-clk pulse after the last pixel of a frame is written
//   hsync, vsync      : active-high syncs
//   hblank, vblank    : outside the active columns / lines
//   r, g, b           : grey level of the pixel, 0 while blanked
module lcd_scanout
  import lcd_pkg::*;
#(
  parameter int         H_FP   = 16,
  parameter int         H_SYNC = 16,
  parameter int         H_BP   = 32,
  parameter int         V_FP   = 3,
  parameter int         V_SYNC = 3,
  parameter int         V_BP   = 12,
  parameter logic [7:0] SHADE0 = SHADE0_DEF,
  parameter logic [7:0] SHADE1 = SHADE1_DEF,
  parameter logic [7:0] SHADE2 = SHADE2_DEF,
  parameter logic [7:0] SHADE3 = SHADE3_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_on,
  input  logic       lcd_clkena,
  input  logic [1:0] lcd_data,
  input  logic       ce_pix,
  output logic       frame_done,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b
);

  localparam palette_t  PAL    = {SHADE3, SHADE2, SHADE1, SHADE0};
  localparam pix_addr_t W_LAST = pix_addr_t'(LCD_PIXELS - 1);

  // ---------------- write side ----------------
  pix_addr_t wptr;
  logic      wr_en;

  assign wr_en = !reset && lcd_on && lcd_clkena;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!lcd_on) begin
        wptr <= '0;
      end else if (lcd_clkena) begin
        if (wptr == W_LAST) begin
          wptr       <= '0;
          frame_done <= 1'b1;
        end else begin
          wptr <= wptr + 1'b1;
        end
      end
    end
  end

  // ---------------- stage A: raster counters ----------------
  pix_addr_t raddr;
  sync_t     sync_a;
  logic      active_a;

  lcd_scan_timing #(
    .H_FP  (H_FP),
    .H_SYNC(H_SYNC),
    .H_BP  (H_BP),
    .V_FP  (V_FP),
    .V_SYNC(V_SYNC),
    .V_BP  (V_BP)
  ) u_timing (
    .clk   (clk),
    .reset (reset),
    .ce_pix(ce_pix),
    .raddr (raddr),
    .sync_a(sync_a),
    .active(active_a)
  );

  // ---------------- frame buffer ----------------
  // Nonblocking read and write give read-before-write on an address clash.
  // Reads are limited to the active window so raddr's parked value past the
  // last pixel never indexes the array.
  shade_t fb [LCD_PIXELS];
  shade_t rd_data;
  logic   rd_en;

  assign rd_en = ce_pix && active_a;

  always_ff @(posedge clk) begin
    if (wr_en) fb[wptr] <= lcd_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= fb[raddr];
  end

  // ---------------- stage B / C ----------------
  sync_t      sync_b;
  logic       active_b;
  logic [7:0] grey;

  assign active_b = !(sync_b.hblank || sync_b.vblank);

  always_comb begin
    grey = 8'h00;
    if (active_b) grey = lcd_on ? shade_grey(rd_data, PAL) : SHADE0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_b <= SYNC_IDLE;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
      hblank <= 1'b1;
      vblank <= 1'b1;
      r      <= 8'h00;
      g      <= 8'h00;
      b      <= 8'h00;
    end else if (ce_pix) begin
      sync_b <= sync_a;
      hsync  <= sync_b.hsync;
      vsync  <= sync_b.vsync;
      hblank <= sync_b.hblank;
      vblank <= sync_b.vblank;
      r      <= grey;
      g      <= grey;
      b      <= grey;
    end
  end

endmodule

// File: tb/tb_lcd_scanout.sv
module tb_lcd_scanout;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lcd_on = 1'b0;
  logic       lcd_clkena = 1'b0;
  logic [1:0] lcd_data = 2'd0;
  logic       ce_pix = 1'b0;
  logic       frame_done, hsync, vsync, hblank, vblank;
  logic [7:0] r, g, b;

  lcd_scanout dut (
    .clk       (clk),
    .reset     (reset),
    .lcd_on    (lcd_on),
    .lcd_clkena(lcd_clkena),
    .lcd_data  (lcd_data),
    .ce_pix    (ce_pix),
    .frame_done(frame_done),
    .hsync     (hsync),
    .vsync     (vsync),
    .hblank    (hblank),
    .vblank    (vblank),
    .r         (r),
    .g         (g),
    .b         (b)
  );

  always #5 clk = ~clk;

  localparam int HT   = 224;
  localparam int VT   = 162;
  localparam int FR   = HT * VT;
  localparam int NPIX = 23040;
  localparam int DOT  = 5 * 160 + 10;

  int total = 0;
  int bad   = 0;
  int phase = 0;
  int cyc   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s phase=%0d cyc=%0d got=%0h want=%0h", name, phase, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] grey(input logic [1:0] s);
    case (s)
      2'd0:    return 8'hFF;
      2'd1:    return 8'hAA;
      2'd2:    return 8'h55;
      default: return 8'h00;
    endcase
  endfunction

  // Reference model: raster position is derived from the count of ce_pix
  // pulses since reset; outputs show the position two pulses old.
  logic [1:0] mmem [NPIX];
  bit         mval [NPIX];
  int         m_wp = 0;
  int         npulse = 0;
  int         mx, my;
  bit         m_fd = 0;
  logic [1:0] rd_prev = 2'd0;
  bit         rd_prev_ok = 0;
  bit         e_hs = 0, e_vs = 0, e_hb = 1, e_vb = 1, e_dc = 0;
  logic [7:0] e_rgb = 8'h00;

  always @(posedge clk) begin
    if (reset) begin
      npulse = 0; m_wp = 0; m_fd = 0;
      e_hs = 0; e_vs = 0; e_hb = 1; e_vb = 1; e_rgb = 8'h00; e_dc = 0;
    end else begin
      if (ce_pix) begin
        npulse++;
        if (npulse >= 2) begin
          mx = ((npulse - 2) % FR) % HT;
          my = ((npulse - 2) % FR) / HT;
          e_hb = (mx >= 160);
          e_vb = (my >= 144);
          e_hs = (mx >= 176) && (mx < 192);
          e_vs = (my >= 147) && (my < 150);
          e_dc = 0;
          if (e_hb || e_vb)  e_rgb = 8'h00;
          else if (!lcd_on)  e_rgb = 8'hFF;
          else begin
            e_rgb = grey(rd_prev);
            e_dc  = !rd_prev_ok;
          end
        end
        mx = ((npulse - 1) % FR) % HT;
        my = ((npulse - 1) % FR) / HT;
        if (mx < 160 && my < 144) begin
          rd_prev    = mmem[my * 160 + mx];
          rd_prev_ok = mval[my * 160 + mx];
        end
      end
      m_fd = 0;
      if (!lcd_on) m_wp = 0;
      else if (lcd_clkena) begin
        mmem[m_wp] = lcd_data;
        mval[m_wp] = 1;
        if (m_wp == NPIX - 1) begin m_wp = 0; m_fd = 1; end
        else m_wp++;
      end
    end
  end

  // ena: 0 none, 1 every clk, 2 random; dat: 0 i%4, 1 random, 2 single dot;
  // ce: 1 every clk, 3 every third clk, 2 random
  typedef struct {
    bit rst;
    bit on;
    int ena;
    int dat;
    int ce;
    int cycles;
    int exp_fd;
  } phase_t;

  phase_t tbl [11];
  int q_hsr[$], q_hbf[$], q_vsr[$], q_vsf[$], q_vbf[$];
  bit p_hs = 0, p_hb = 1, p_vs = 0, p_vb = 1;
  int fdc, pix, dark_cnt, dark_cyc, white_cnt, nxt, lines;

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 1, 4,     0};
    tbl[1]  = '{0, 1, 1, 0, 1, 23040, 1};
    tbl[2]  = '{0, 1, 0, 0, 1, 5,     0};
    tbl[3]  = '{0, 1, 1, 1, 1, 1000,  0};
    tbl[4]  = '{0, 0, 2, 1, 1, 20,    0};
    tbl[5]  = '{0, 1, 1, 2, 1, 23040, 1};
    tbl[6]  = '{1, 1, 0, 0, 1, 36300, 0};
    tbl[7]  = '{0, 1, 0, 0, 3, 2100,  0};
    tbl[8]  = '{0, 0, 2, 1, 2, 500,   0};
    tbl[9]  = '{1, 1, 0, 0, 1, 1300,  0};
    tbl[10] = '{0, 1, 2, 1, 2, 600,   0};

    @(negedge clk);
    for (int ph = 0; ph < 11; ph++) begin
      phase = ph; fdc = 0; pix = 0;
      dark_cnt = 0; dark_cyc = -1; white_cnt = 0;
      q_hsr.delete(); q_hbf.delete(); q_vsr.delete(); q_vsf.delete(); q_vbf.delete();
      for (int c = 0; c < tbl[ph].cycles; c++) begin
        cyc    = c;
        reset  = tbl[ph].rst && (c < 2);
        lcd_on = tbl[ph].on;
        case (tbl[ph].ena)
          0:       lcd_clkena = 1'b0;
          1:       lcd_clkena = 1'b1;
          default: lcd_clkena = 1'($urandom_range(0, 1));
        endcase
        case (tbl[ph].dat)
          0:       lcd_data = 2'(pix % 4);
          1:       lcd_data = 2'($urandom_range(0, 3));
          default: lcd_data = (pix == DOT) ? 2'd3 : 2'd0;
        endcase
        if (lcd_clkena) pix++;
        case (tbl[ph].ce)
          1:       ce_pix = 1'b1;
          3:       ce_pix = (c % 3 == 0);
          default: ce_pix = 1'($urandom_range(0, 1));
        endcase
        @(negedge clk);
        chk("sync_blank", int'({hsync, vsync, hblank, vblank}), int'({e_hs, e_vs, e_hb, e_vb}));
        if (!e_dc) chk("rgb", int'({r, g, b}), int'({e_rgb, e_rgb, e_rgb}));
        chk("frame_done", int'(frame_done), int'(m_fd));
        fdc += int'(frame_done);
        if (hsync && !p_hs)  q_hsr.push_back(c);
        if (!hblank && p_hb) q_hbf.push_back(c);
        if (vsync && !p_vs)  q_vsr.push_back(c);
        if (!vsync && p_vs)  q_vsf.push_back(c);
        if (!vblank && p_vb) q_vbf.push_back(c);
        p_hs = hsync; p_hb = hblank; p_vs = vsync; p_vb = vblank;
        if (!hblank && !vblank) begin
          if (r == 8'h00) begin dark_cnt++; dark_cyc = c; end
          else if (r == 8'hFF) white_cnt++;
        end
      end
      chk("frame_done_count", fdc, tbl[ph].exp_fd);

      if (ph == 6) begin
        if (q_hsr.size() < 2 || q_hbf.size() < 1 || q_vsr.size() < 1 ||
            q_vsf.size() < 1 || q_vbf.size() < 2) begin
          chk("edge_count_6", q_hsr.size() + q_vbf.size(), 0);
        end else begin
          chk("hblank_fall_after_reset", q_hbf[0], 3);
          chk("hsync_after_hblank", q_hsr[0] - q_hbf[0], 176);
          chk("hsync_period", q_hsr[1] - q_hsr[0], HT);
          chk("vsync_width", q_vsf[0] - q_vsr[0], 3 * HT);
          chk("frame_period", q_vbf[1] - q_vbf[0], FR);
          lines = 0;
          foreach (q_hsr[i]) if (q_hsr[i] >= q_vbf[0] && q_hsr[i] < q_vbf[1]) lines++;
          chk("lines_per_frame", lines, VT);
        end
      end

      if (ph == 7) begin
        if (q_hsr.size() < 2 || q_hbf.size() < 1) begin
          chk("edge_count_7", q_hsr.size(), 2);
        end else begin
          chk("hsync_period_ce3", q_hsr[1] - q_hsr[0], 3 * HT);
          nxt = -1;
          foreach (q_hsr[i]) if (nxt < 0 && q_hsr[i] > q_hbf[0]) nxt = q_hsr[i];
          chk("hsync_after_hblank_ce3", nxt - q_hbf[0], 3 * 176);
        end
      end

      if (ph == 9) begin
        chk("dot_count", dark_cnt, 1);
        chk("dot_position", dark_cyc, 3 + 5 * HT + 10);
        chk("white_count", white_cnt, 959);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
